ddr3_pkt_wbuf: RTL and testbench



---
 rtl/ddr3_pkt_pkg.sv | 23 ++
 rtl/pkt_wbuf_dpram.sv | 40 ++++
 rtl/ddr3_pkt_wbuf.sv | 340 ++++++++++++++++++++++++++++++++++
 tb/tb_ddr3_pkt_wbuf.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr3_pkt_pkg.sv
// ddr3_pkt_pkg: shared constants and FSM encodings for the DDR3 packet write buffer.
package ddr3_pkt_pkg;

    // Width of one TS / DDR burst word.
    localparam int DATA_W        = 32;
    // Default packet length: one header word plus 47 TS words.
    localparam int PKT_WORDS_DEF = 48;

    // Write-side FSM, one-hot.
    typedef enum logic [2:0] {
        W_IDLE    = 3'b001,
        W_STORE   = 3'b010,
        W_DISCARD = 3'b100
    } wr_state_t;

    // Read-side FSM, one-hot.
    typedef enum logic [2:0] {
        R_IDLE = 3'b001,
        R_REQ  = 3'b010,
        R_XFER = 3'b100
    } rd_state_t;

endpackage

// File: rtl/pkt_wbuf_dpram.sv
// pkt_wbuf_dpram: simple dual-port RAM for the packet buffer, one write port,
// one read port with a single registered read stage.
module pkt_wbuf_dpram
    import ddr3_pkt_pkg::*;
#(
    parameter int ADDR_BITS = 9,
    parameter int DATA_BITS = DATA_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] waddr,
    input  logic [DATA_BITS-1:0] wdata,
    input  logic                 re,
    input  logic [ADDR_BITS-1:0] raddr,
    output logic [DATA_BITS-1:0] rdata
);

    logic [DATA_BITS-1:0] mem_r [0:(2**ADDR_BITS)-1];
    logic [DATA_BITS-1:0] rdata_r;

    // Storage write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Registered read port; cleared on reset so the burst data output starts at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_r <= {DATA_BITS{1'b0}};
        end else if (re) begin
            rdata_r <= mem_r[raddr];
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/ddr3_pkt_wbuf.sv
// ddr3_pkt_wbuf: store-and-forward packet buffer between the per-program packet
// filter and the DDR3 write controller. Only complete packets of exactly
// PKT_WORDS words are committed; everything else is rewound and dropped.
// Optional feature: define DROP_STAT_EN to enable the saturating drop counters
// (ovf_drop_cnt, len_err_cnt); without it both ports are tied to zero.
module ddr3_pkt_wbuf
    import ddr3_pkt_pkg::*;
#(
    parameter int DEPTH_BITS = 9,
    parameter int PKT_WORDS  = PKT_WORDS_DEF,
    parameter int WCNT_BITS  = 6,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_W-1:0]     ts_i_data,
    input  logic                  ts_i_val,
    input  logic                  ts_i_sop,
    input  logic                  ts_i_eop,
    output logic                  ddr_wr_req,
    input  logic                  ddr_wr_ack,
    input  logic                  ddr_wr_rdy,
    output logic                  ddr_wr_val,
    output logic [DATA_W-1:0]     ddr_wr_data,
    output logic                  ddr_wr_sop,
    output logic                  ddr_wr_eop,
    output logic [DEPTH_BITS:0]   buf_pkt_num,
    output logic [CNT_WIDTH-1:0]  ovf_drop_cnt,
    output logic [CNT_WIDTH-1:0]  len_err_cnt
);

    localparam int                   PW          = DEPTH_BITS + 1;
    localparam logic [PW-1:0]        DEPTH_P     = PW'(2 ** DEPTH_BITS);
    localparam logic [PW-1:0]        PKT_P       = PW'(PKT_WORDS);
    localparam logic [PW-1:0]        PTR_ZERO    = {PW{1'b0}};
    localparam logic [PW-1:0]        PTR_ONE     = PW'(1);
    localparam logic [WCNT_BITS-1:0] WC_ZERO     = {WCNT_BITS{1'b0}};
    localparam logic [WCNT_BITS-1:0] WC_ONE      = WCNT_BITS'(1);
    localparam logic [WCNT_BITS-1:0] LAST_WC     = WCNT_BITS'(PKT_WORDS - 1);
    localparam logic                 SINGLE_WORD = (PKT_WORDS == 1) ? 1'b1 : 1'b0;

    // ---------------- write side ----------------
    wr_state_t              wr_state_r, wr_state_nx_s, start_nx_s;
    logic [PW-1:0]          wr_ptr_r, wr_ptr_nx_s;
    logic [PW-1:0]          wr_commit_ptr_r, wr_commit_nx_s;
    logic [WCNT_BITS-1:0]   wcnt_r, wcnt_nx_s;
    logic                   wr_en_s;
    logic [DEPTH_BITS-1:0]  wr_addr_s;
    logic                   commit_s;
    logic [PW-1:0]          free_s;
    logic                   space_ok_s;
    logic                   sop_s, eop_s, cont_s, in_store_s, wcnt_last_s;

    // ---------------- read side ----------------
    rd_state_t              rd_state_r, rd_state_nx_s;
    logic [PW-1:0]          rd_ptr_r, rd_release_ptr_r;
    logic [WCNT_BITS-1:0]   rcnt_r, rcnt_nx_s;
    logic                   rd_en_s, release_s;
    logic [DEPTH_BITS:0]    pkt_num_r;
    logic                   req_r, val_r, sop_r, eop_r;
    logic [DATA_W-1:0]      rdata_s;

    // Space is measured against committed data only; a partial packet never
    // counts, since it is rewound if it fails.
    assign free_s      = DEPTH_P - (wr_commit_ptr_r - rd_release_ptr_r);
    assign space_ok_s  = (free_s >= PKT_P);
    assign sop_s       = ts_i_val & ts_i_sop;
    assign eop_s       = ts_i_val & ts_i_eop;
    assign cont_s      = ts_i_val & ~ts_i_sop;
    assign in_store_s  = (wr_state_r == W_STORE);
    assign wcnt_last_s = (wcnt_r == LAST_WC);

    // Write FSM state, pointers and in-packet word counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_state_r      <= W_IDLE;
            wr_ptr_r        <= PTR_ZERO;
            wr_commit_ptr_r <= PTR_ZERO;
            wcnt_r          <= WC_ZERO;
        end else begin
            wr_state_r      <= wr_state_nx_s;
            wr_ptr_r        <= wr_ptr_nx_s;
            wr_commit_ptr_r <= wr_commit_nx_s;
            wcnt_r          <= wcnt_nx_s;
        end
    end

    // Outcome of evaluating a sop, which is the same from every write state.
    always_comb begin
        if (!space_ok_s) begin
            start_nx_s = ts_i_eop ? W_IDLE : W_DISCARD;
        end else if (ts_i_eop) begin
            start_nx_s = W_IDLE;
        end else begin
            start_nx_s = W_STORE;
        end
    end

    // Write FSM next state.
    always_comb begin
        wr_state_nx_s = wr_state_r;
        case (wr_state_r)
            W_IDLE: begin
                if (sop_s) begin
                    wr_state_nx_s = start_nx_s;
                end else begin
                    wr_state_nx_s = W_IDLE;
                end
            end
            W_STORE: begin
                if (sop_s) begin
                    wr_state_nx_s = start_nx_s;
                end else if (ts_i_val) begin
                    if (wcnt_last_s) begin
                        wr_state_nx_s = ts_i_eop ? W_IDLE : W_DISCARD;
                    end else if (ts_i_eop) begin
                        wr_state_nx_s = W_IDLE;
                    end else begin
                        wr_state_nx_s = W_STORE;
                    end
                end else begin
                    wr_state_nx_s = W_STORE;
                end
            end
            W_DISCARD: begin
                if (sop_s) begin
                    wr_state_nx_s = start_nx_s;
                end else if (eop_s) begin
                    wr_state_nx_s = W_IDLE;
                end else begin
                    wr_state_nx_s = W_DISCARD;
                end
            end
            default: wr_state_nx_s = W_IDLE;
        endcase
    end

    // Write datapath: RAM write strobe, pointer advance, rewind and commit.
    always_comb begin
        wr_en_s        = 1'b0;
        wr_addr_s      = wr_ptr_r[DEPTH_BITS-1:0];
        wr_ptr_nx_s    = wr_ptr_r;
        wr_commit_nx_s = wr_commit_ptr_r;
        wcnt_nx_s      = wcnt_r;
        commit_s       = 1'b0;
        if (sop_s) begin
            // A sop always restarts from the last commit point, dropping any partial packet.
            wr_addr_s   = wr_commit_ptr_r[DEPTH_BITS-1:0];
            wr_ptr_nx_s = wr_commit_ptr_r;
            wcnt_nx_s   = WC_ZERO;
            if (!space_ok_s) begin
                wr_en_s = 1'b0;
            end else if (ts_i_eop) begin
                if (SINGLE_WORD) begin
                    wr_en_s        = 1'b1;
                    commit_s       = 1'b1;
                    wr_ptr_nx_s    = wr_commit_ptr_r + PTR_ONE;
                    wr_commit_nx_s = wr_commit_ptr_r + PTR_ONE;
                end else begin
                    wr_en_s = 1'b0;
                end
            end else begin
                wr_en_s     = 1'b1;
                wr_ptr_nx_s = wr_commit_ptr_r + PTR_ONE;
                wcnt_nx_s   = WC_ONE;
            end
        end else if (cont_s && in_store_s) begin
            if (wcnt_last_s) begin
                wcnt_nx_s = WC_ZERO;
                if (ts_i_eop) begin
                    wr_en_s        = 1'b1;
                    commit_s       = 1'b1;
                    wr_ptr_nx_s    = wr_ptr_r + PTR_ONE;
                    wr_commit_nx_s = wr_ptr_r + PTR_ONE;
                end else begin
                    wr_ptr_nx_s = wr_commit_ptr_r;
                end
            end else if (ts_i_eop) begin
                wcnt_nx_s   = WC_ZERO;
                wr_ptr_nx_s = wr_commit_ptr_r;
            end else begin
                wr_en_s     = 1'b1;
                wr_ptr_nx_s = wr_ptr_r + PTR_ONE;
                wcnt_nx_s   = wcnt_r + WC_ONE;
            end
        end else begin
            wr_en_s = 1'b0;
        end
    end

    // ---------------- packet storage ----------------
    pkt_wbuf_dpram #(
        .ADDR_BITS (DEPTH_BITS),
        .DATA_BITS (DATA_W)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_en_s),
        .waddr (wr_addr_s),
        .wdata (ts_i_data),
        .re    (rd_en_s),
        .raddr (rd_ptr_r[DEPTH_BITS-1:0]),
        .rdata (rdata_s)
    );

    // Read FSM state, pointers and burst word counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_state_r       <= R_IDLE;
            rd_ptr_r         <= PTR_ZERO;
            rd_release_ptr_r <= PTR_ZERO;
            rcnt_r           <= WC_ZERO;
        end else begin
            rd_state_r <= rd_state_nx_s;
            rcnt_r     <= rcnt_nx_s;
            if (rd_en_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            if (release_s) begin
                rd_release_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

    // Read FSM next state.
    always_comb begin
        rd_state_nx_s = rd_state_r;
        case (rd_state_r)
            R_IDLE: begin
                if (pkt_num_r != {(DEPTH_BITS+1){1'b0}}) begin
                    rd_state_nx_s = R_REQ;
                end else begin
                    rd_state_nx_s = R_IDLE;
                end
            end
            R_REQ: begin
                if (ddr_wr_ack) begin
                    rd_state_nx_s = R_XFER;
                end else begin
                    rd_state_nx_s = R_REQ;
                end
            end
            R_XFER: begin
                if (ddr_wr_rdy && (rcnt_r == LAST_WC)) begin
                    rd_state_nx_s = R_IDLE;
                end else begin
                    rd_state_nx_s = R_XFER;
                end
            end
            default: rd_state_nx_s = R_IDLE;
        endcase
    end

    // Read datapath: RAM read strobe, release of a fully issued packet, word count.
    always_comb begin
        rd_en_s   = (rd_state_r == R_XFER) & ddr_wr_rdy;
        release_s = rd_en_s & (rcnt_r == LAST_WC);
        rcnt_nx_s = rcnt_r;
        if ((rd_state_r == R_REQ) && ddr_wr_ack) begin
            rcnt_nx_s = WC_ZERO;
        end else if (rd_en_s) begin
            rcnt_nx_s = release_s ? WC_ZERO : (rcnt_r + WC_ONE);
        end else begin
            rcnt_nx_s = rcnt_r;
        end
    end

    // Burst interface outputs; flags line up with the RAM's registered read data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_r <= 1'b0;
            val_r <= 1'b0;
            sop_r <= 1'b0;
            eop_r <= 1'b0;
        end else begin
            req_r <= (rd_state_nx_s == R_REQ);
            val_r <= rd_en_s;
            sop_r <= rd_en_s & (rcnt_r == WC_ZERO);
            eop_r <= release_s;
        end
    end

    // Count of committed packets not yet released; commit and release cancel out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt_num_r <= {(DEPTH_BITS+1){1'b0}};
        end else begin
            case ({commit_s, release_s})
                2'b10:   pkt_num_r <= pkt_num_r + {{DEPTH_BITS{1'b0}}, 1'b1};
                2'b01:   pkt_num_r <= pkt_num_r - {{DEPTH_BITS{1'b0}}, 1'b1};
                default: pkt_num_r <= pkt_num_r;
            endcase
        end
    end

    assign ddr_wr_req  = req_r;
    assign ddr_wr_val  = val_r;
    assign ddr_wr_data = rdata_s;
    assign ddr_wr_sop  = sop_r;
    assign ddr_wr_eop  = eop_r;
    assign buf_pkt_num = pkt_num_r;

`ifdef DROP_STAT_EN
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    logic                 ovf_ev_s, len_ev_s;
    logic [CNT_WIDTH-1:0] ovf_cnt_r, len_cnt_r;

    // Overflow: a sop finds too little room. Length error: sop cutting a packet,
    // lone sop&eop, early eop, or the final word arriving without eop.
    assign ovf_ev_s = sop_s & ~space_ok_s;
    assign len_ev_s = (sop_s & in_store_s)
                    | (sop_s & space_ok_s & ts_i_eop & ~SINGLE_WORD)
                    | (cont_s & in_store_s & (wcnt_last_s ^ ts_i_eop));

    // Saturating drop statistics.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_cnt_r <= CNT_ZERO;
            len_cnt_r <= CNT_ZERO;
        end else begin
            if (ovf_ev_s && (ovf_cnt_r != CNT_MAX)) begin
                ovf_cnt_r <= ovf_cnt_r + CNT_ONE;
            end
            if (len_ev_s && (len_cnt_r != CNT_MAX)) begin
                len_cnt_r <= len_cnt_r + CNT_ONE;
            end
        end
    end

    assign ovf_drop_cnt = ovf_cnt_r;
    assign len_err_cnt  = len_cnt_r;
`else
    assign ovf_drop_cnt = {CNT_WIDTH{1'b0}};
    assign len_err_cnt  = {CNT_WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_ddr3_pkt_wbuf.sv
// tb_ddr3_pkt_wbuf: scoreboard bench for ddr3_pkt_wbuf. A packet-level reference
// model decides which packets survive; surviving words are queued and a monitor
// compares them against the burst interface.
module tb_ddr3_pkt_wbuf;

    localparam int DEPTH_BITS = 9;
    localparam int PKT        = 48;
    localparam int WCNT_BITS  = 6;
    localparam int CNT_WIDTH  = 16;
    localparam int DEPTH      = 1 << DEPTH_BITS;
`ifdef DROP_STAT_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic [31:0]          ts_i_data = 32'h0;
    logic                 ts_i_val = 1'b0, ts_i_sop = 1'b0, ts_i_eop = 1'b0;
    logic                 ddr_wr_req, ddr_wr_val, ddr_wr_sop, ddr_wr_eop;
    logic                 ddr_wr_ack = 1'b0, ddr_wr_rdy = 1'b0;
    logic [31:0]          ddr_wr_data;
    logic [DEPTH_BITS:0]  buf_pkt_num;
    logic [CNT_WIDTH-1:0] ovf_drop_cnt, len_err_cnt;

    ddr3_pkt_wbuf #(
        .DEPTH_BITS (DEPTH_BITS),
        .PKT_WORDS  (PKT),
        .WCNT_BITS  (WCNT_BITS),
        .CNT_WIDTH  (CNT_WIDTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ts_i_data    (ts_i_data),
        .ts_i_val     (ts_i_val),
        .ts_i_sop     (ts_i_sop),
        .ts_i_eop     (ts_i_eop),
        .ddr_wr_req   (ddr_wr_req),
        .ddr_wr_ack   (ddr_wr_ack),
        .ddr_wr_rdy   (ddr_wr_rdy),
        .ddr_wr_val   (ddr_wr_val),
        .ddr_wr_data  (ddr_wr_data),
        .ddr_wr_sop   (ddr_wr_sop),
        .ddr_wr_eop   (ddr_wr_eop),
        .buf_pkt_num  (buf_pkt_num),
        .ovf_drop_cnt (ovf_drop_cnt),
        .len_err_cnt  (len_err_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Expected burst words, {sop, eop, data}.
    logic [33:0] exp_q[$];

    // Reference model state (stimulus side).
    int          m_commits = 0;
    int          m_ovf     = 0;
    int          m_len     = 0;
    bit          m_collect = 1'b0;
    logic [31:0] m_cur[$];

    // Monitor state.
    int mon_pkts     = 0;
    int mon_word_idx = 0;
    bit rdy_prev     = 1'b0;

    int rdy_mode = 0;   // 0: always ready, 1: alternate, 2: random
    bit ack_en   = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [63:0] exp_cnt(input int n);
        return STATS ? 64'(n) : 64'd0;
    endfunction

    // Packet-level model: a packet survives only if its sop found room for a full
    // packet and exactly PKT words arrived with eop on the last one.
    task automatic model_word(input logic [31:0] d, input bit s, input bit e);
        int used;
        used = (m_commits - mon_pkts) * PKT;
        if (s) begin
            if (m_collect) m_len++;
            m_collect = 1'b0;
            m_cur.delete();
            if (DEPTH - used < PKT) m_ovf++;
            else if (e) m_len++;
            else begin
                m_cur.push_back(d);
                m_collect = 1'b1;
            end
        end else if (m_collect) begin
            m_cur.push_back(d);
            if (m_cur.size() == PKT) begin
                m_collect = 1'b0;
                if (e) begin
                    for (int i = 0; i < PKT; i++)
                        exp_q.push_back({(i == 0), (i == PKT - 1), m_cur[i]});
                    m_commits++;
                end else m_len++;
            end else if (e) begin
                m_collect = 1'b0;
                m_len++;
            end
        end
    endtask

    task automatic send_word(input logic [31:0] d, input bit s, input bit e);
        ts_i_data = d; ts_i_sop = s; ts_i_eop = e; ts_i_val = 1'b1;
        model_word(d, s, e);
        @(negedge clk);
        ts_i_val = 1'b0; ts_i_sop = 1'b0; ts_i_eop = 1'b0;
    endtask

    // n words with data base+i; eop on index eop_at (negative for none).
    task automatic send_pkt(input int n, input int eop_at, input logic [31:0] base);
        for (int i = 0; i < n; i++) send_word(base + 32'(i), (i == 0), (i == eop_at));
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || buf_pkt_num != '0) && n < 6000) begin
            @(negedge clk);
            n++;
        end
        check({name, "_drain_in_time"}, 64'(n < 6000), 64'd1);
        repeat (4) @(negedge clk);
        check({name, "_pkt_num"}, 64'(buf_pkt_num), 64'(m_commits - mon_pkts));
        check({name, "_ovf_cnt"}, 64'(ovf_drop_cnt), exp_cnt(m_ovf));
        check({name, "_len_cnt"}, 64'(len_err_cnt), exp_cnt(m_len));
    endtask

    // Ready driver, changes just after the rising edge.
    initial forever begin
        @(posedge clk);
        #1;
        case (rdy_mode)
            0:       ddr_wr_rdy = 1'b1;
            1:       ddr_wr_rdy = ~ddr_wr_rdy;
            default: ddr_wr_rdy = 1'($urandom_range(0, 1));
        endcase
    end

    // Controller stand-in: grants a pending request after a short random delay.
    initial forever begin
        @(negedge clk);
        if (ack_en && ddr_wr_req && !rst) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            ddr_wr_ack = 1'b1;
            @(negedge clk);
            ddr_wr_ack = 1'b0;
        end
    end

    // Monitor: compares every presented burst word against the scoreboard.
    initial forever begin
        logic [33:0] e;
        @(negedge clk);
        if (rst) begin
            exp_q.delete();
            mon_pkts     = 0;
            mon_word_idx = 0;
        end else if (ddr_wr_val) begin
            check("val_after_rdy", 64'(rdy_prev), 64'd1);
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_word: got 0x%0h with nothing expected at %0t",
                         {ddr_wr_sop, ddr_wr_eop, ddr_wr_data}, $time);
            end else begin
                e = exp_q.pop_front();
                check("burst_word", 64'({ddr_wr_sop, ddr_wr_eop, ddr_wr_data}), 64'(e));
                mon_word_idx++;
                if (e[32]) begin
                    mon_pkts++;
                    mon_word_idx = 0;
                end
            end
        end
        rdy_prev = ddr_wr_rdy;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, kind, len;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_outputs",
              64'({ddr_wr_req, ddr_wr_val, ddr_wr_sop, ddr_wr_eop, ddr_wr_data}), 64'd0);
        check("reset_pkt_num", 64'(buf_pkt_num), 64'd0);
        check("reset_counters", 64'({ovf_drop_cnt, len_err_cnt}), 64'd0);

        // 1: single packet, commit timing, request held until granted.
        rdy_mode = 0;
        ack_en   = 1'b0;
        send_pkt(PKT - 1, -1, 32'd0);
        check("pkt_num_before_commit", 64'(buf_pkt_num), 64'd0);
        send_word(32'(PKT - 1), 1'b0, 1'b1);
        check("pkt_num_after_commit", 64'(buf_pkt_num), 64'd1);
        repeat (4) @(negedge clk);
        check("req_waits_for_ack", 64'(ddr_wr_req), 64'd1);
        ack_en = 1'b1;
        wait_drain("single");
        check("req_idle_after_xfer", 64'(ddr_wr_req), 64'd0);

        // 2: twelve packets without grants, buffer fills at ten.
        ack_en = 1'b0;
        for (int p = 0; p < 12; p++) send_pkt(PKT, PKT - 1, 32'(p) << 16);
        repeat (2) @(negedge clk);
        check("full_pkt_num", 64'(buf_pkt_num), 64'(m_commits - mon_pkts));
        check("full_ovf_cnt", 64'(ovf_drop_cnt), exp_cnt(m_ovf));
        ack_en = 1'b1;
        wait_drain("full");

        // 3: early eop on word 30, then a good packet.
        send_pkt(30, 29, 32'hA000_0000);
        repeat (2) @(negedge clk);
        check("short_pkt_num", 64'(buf_pkt_num), 64'd0);
        send_pkt(PKT, PKT - 1, 32'hB000_0000);
        wait_drain("short");

        // 4: 50-word packet, then a sop on the next cycle.
        send_pkt(50, 49, 32'hC000_0000);
        send_pkt(PKT, PKT - 1, 32'hD000_0000);
        wait_drain("long");

        // 5: alternating ready during transfers.
        rdy_mode = 1;
        send_pkt(PKT, PKT - 1, 32'hE000_0000);
        send_pkt(PKT, PKT - 1, 32'hF000_0000);
        wait_drain("toggle");

        // 6: reset in the middle of a transfer.
        rdy_mode = 0;
        send_pkt(PKT, PKT - 1, 32'h1234_0000);
        n = 0;
        while (mon_word_idx < 20 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("reached_word_20", 64'(mon_word_idx >= 20), 64'd1);
        rst = 1'b1;
        #1;
        check("midreset_outputs",
              64'({ddr_wr_req, ddr_wr_val, ddr_wr_sop, ddr_wr_eop, ddr_wr_data}), 64'd0);
        check("midreset_pkt_num", 64'(buf_pkt_num), 64'd0);
        check("midreset_counters", 64'({ovf_drop_cnt, len_err_cnt}), 64'd0);
        repeat (3) @(negedge clk);
        m_commits = 0; m_ovf = 0; m_len = 0; m_collect = 1'b0; m_cur.delete();
        rst = 1'b0;
        @(negedge clk);
        send_pkt(PKT, PKT - 1, 32'h5678_0000);
        check("post_reset_pkt_num", 64'(buf_pkt_num), 64'd1);
        wait_drain("post_reset");

        // 7: random mix of good, short, long, cut-off and stray words.
        rdy_mode = 2;
        for (int u = 0; u < 40; u++) begin
            n = 0;
            while (DEPTH - (m_commits - mon_pkts) * PKT < 2 * PKT && n < 4000) begin
                @(negedge clk);
                n++;
            end
            if (n >= 4000) check("space_wait", 64'(n), 64'd0);
            kind = $urandom_range(0, 9);
            if (kind < 5) send_pkt(PKT, PKT - 1, $urandom);
            else if (kind < 7) begin
                len = $urandom_range(1, PKT - 1);
                send_pkt(len, len - 1, $urandom);
            end else if (kind == 7) begin
                len = $urandom_range(PKT + 1, PKT + 4);
                send_pkt(len, len - 1, $urandom);
            end else if (kind == 8) send_pkt($urandom_range(2, PKT - 1), -1, $urandom);
            else begin
                for (int w = 0; w < $urandom_range(1, 3); w++) send_word($urandom, 1'b0, 1'($urandom_range(0, 1)));
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        wait_drain("random");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
